mult6x6_seq_ctrl: RTL

- Sequential controller that computes an unsigned 6x6 -> 12-bit product.
- Time-multiplexes one instance of the existing 3x3 array multiplier over four partial-product steps and accumulates the results.
- Sits between a requester (valid/ready input) and a consumer (valid/ready output).
- Used wherever a wider multiply is needed without replicating the combinational array.

---
 rtl/mult6x6_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mult6x6_seq_ctrl.sv
// Unsigned 6x6 -> 12-bit multiplier that reuses one 3x3 array over four steps.
// Optional macro MULT_SEQ_ZERO_SKIP_EN: a zero operand goes straight from IDLE to DONE.

module mult3x3_array (
  input  logic [2:0] i_a,
  input  logic [2:0] i_b,
  output logic [5:0] o_p
);
  logic [2:0] w_row0;
  logic [2:0] w_row1;
  logic [2:0] w_row2;

  assign w_row0 = i_a & {3{i_b[0]}};
  assign w_row1 = i_a & {3{i_b[1]}};
  assign w_row2 = i_a & {3{i_b[2]}};
  assign o_p    = {3'b000, w_row0} + {2'b00, w_row1, 1'b0} + {1'b0, w_row2, 2'b00};
endmodule

module mult6x6_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in1,
  input  logic [5:0]  in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] product,
  output logic        busy,
  output logic [1:0]  step
);
  localparam int HALF = 3;
  localparam int FULL = 6;
  localparam int PROD = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_step;
  logic [FULL-1:0]   r_a;
  logic [FULL-1:0]   r_b;
  logic [PROD-1:0]   r_acc;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [HALF-1:0]   w_mul_a;
  logic [HALF-1:0]   w_mul_b;
  logic [2*HALF-1:0] w_pp;
  logic [PROD-1:0]   w_pp_ext;
  logic [PROD-1:0]   w_pp_shift;
  logic              w_accept;

  // step[1] picks the high half of a, step[0] the high half of b
  assign w_mul_a  = r_step[1] ? r_a[FULL-1:HALF] : r_a[HALF-1:0];
  assign w_mul_b  = r_step[0] ? r_b[FULL-1:HALF] : r_b[HALF-1:0];
  assign w_pp_ext = {{(PROD-2*HALF){1'b0}}, w_pp};
  assign w_pp_shift = (r_step == 2'd0) ? w_pp_ext :
                      (r_step == 2'd3) ? (w_pp_ext << (2*HALF)) :
                                         (w_pp_ext << HALF);
  assign w_accept = in_valid && r_in_ready;

  mult3x3_array u_arr (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= 2'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a        <= in1;
            r_b        <= in2;
            r_acc      <= '0;
            r_step     <= 2'd0;
            r_in_ready <= 1'b0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            if ((in1 == '0) || (in2 == '0)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
            end
`else
            r_state <= S_MUL;
            r_busy  <= 1'b1;
`endif
          end
        end
        S_MUL: begin
          r_acc  <= r_acc + w_pp_shift;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_step      <= 2'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign step      = r_step;
  assign product   = r_acc;
endmodule
